ddr3_app_scheduler: RTL and testbench

Sequences the MIG DDR3 user (app) interface between two requesters: the USB-to-DDR3 write FIFO (256-bit words) and the DDR3 read/playback path feeding the ddr3-to-USB (later DAC) FIFO. It grants bursts round-robin and tracks written and read address pointers. It issues write and read commands with correct data/command handshakes. Read issue is throttled by credits so the destination FIFO can never overflow. It sits between the FIFOs and `ddr3_controller`, and replaces the fixed address/count tie-offs.

---
 rtl/ddr3_sched_pkg.sv | 21 ++
 rtl/ddr3_rd_credit.sv | 40 ++++
 rtl/ddr3_app_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_ddr3_app_scheduler.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_sched_pkg.sv
// Shared types and constants for the DDR3 app-interface scheduler.
package ddr3_sched_pkg;

    localparam int PTR_W = 21;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } sched_state_e;

    function automatic logic [31:0] word_addr(input logic [PTR_W-1:0] ptr,
                                              input int unsigned step);
        return 32'(ptr) * step;
    endfunction

endpackage

// File: rtl/ddr3_rd_credit.sv
// Outstanding-read tracker: allows another read only while the destination FIFO
// has room for every read in flight plus one more.
module ddr3_rd_credit #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             sys_rst,
    input  logic             rd_accept_i,
    input  logic             rd_valid_i,
    input  logic [CNT_W-1:0] space_i,
    output logic             credit_ok_o
);

    logic [CNT_W:0] outstanding_q;
    logic [CNT_W:0] outstanding_d;

    // Next outstanding count; accept and return in one cycle cancel out.
    always_comb begin
        outstanding_d = outstanding_q;
        if (rd_accept_i && !rd_valid_i) begin
            outstanding_d = outstanding_q + (CNT_W+1)'(1);
        end else if (!rd_accept_i && rd_valid_i && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - (CNT_W+1)'(1);
        end else begin
            outstanding_d = outstanding_q;
        end
    end

    // Outstanding-read counter register.
    always_ff @(posedge clk) begin
        if (!sys_rst) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    assign credit_ok_o = ({1'b0, space_i} > outstanding_d);

endmodule

// File: rtl/ddr3_app_scheduler.sv
// Round-robin write/read burst scheduler for the MIG DDR3 app interface.
// Optional looped playback is enabled with the DDR3_SCHED_LOOP_EN macro.
module ddr3_app_scheduler
    import ddr3_sched_pkg::*;
#(
    parameter int          ADDR_W    = 29,
    parameter int          DATA_W    = 256,
    parameter int          BURST_LEN = 8,
    parameter int unsigned ADDR_STEP = 8,
    parameter int          MEM_WORDS = 1048576,
    parameter int          CNT_W     = 10
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              init_calib_complete,
    input  logic              clear,
    input  logic              loop_en,
    input  logic [DATA_W-1:0] wr_fifo_dout,
    input  logic [CNT_W-1:0]  wr_fifo_count,
    output logic              wr_fifo_rd_en,
    input  logic [CNT_W-1:0]  rd_fifo_space,
    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    input  logic              app_rdy,
    output logic [DATA_W-1:0] app_wdf_data,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_wdf_rdy,
    input  logic              app_rd_data_valid,
    output logic [PTR_W-1:0]  wr_level,
    output logic [PTR_W-1:0]  rd_ptr,
    output logic              busy
);

    localparam int BEAT_W = $clog2(BURST_LEN + 1);

    sched_state_e      state_q, state_d;
    logic [PTR_W-1:0]  wr_level_q, wr_level_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              last_rd_q, last_rd_d;
    logic              clear_pend_q, clear_pend_d;
    logic              app_en_q, app_en_d;
    logic              wren_q, wren_d;
    logic              pop_q, pop_d;
    logic              busy_q, busy_d;
    logic [2:0]        app_cmd_q, app_cmd_d;
    logic [ADDR_W-1:0] app_addr_q, app_addr_d;

    logic              rd_accept_s, credit_ok_s, loop_wrap_s;
    logic              wr_elig_s, rd_elig_s, cmd_left_s, data_left_s;
    logic [PTR_W-1:0]  rd_ptr_arb_s;

    assign rd_accept_s = (state_q == ST_RD) && app_en_q && app_rdy;

    ddr3_rd_credit #(.CNT_W(CNT_W)) u_credit (
        .clk         (clk),
        .sys_rst     (sys_rst),
        .rd_accept_i (rd_accept_s),
        .rd_valid_i  (app_rd_data_valid),
        .space_i     (rd_fifo_space),
        .credit_ok_o (credit_ok_s)
    );

`ifdef DDR3_SCHED_LOOP_EN
    assign loop_wrap_s = loop_en && (rd_ptr_q == wr_level_q) && (wr_level_q != '0);
`else
    // loop_en has no effect in this build.
    assign loop_wrap_s = loop_en & 1'b0;
`endif

    // The FIFO count still includes a word whose pop is in flight this cycle.
    assign wr_elig_s    = (wr_fifo_count > {{(CNT_W-1){1'b0}}, pop_q})
                       && (wr_level_q < PTR_W'(MEM_WORDS));
    assign rd_ptr_arb_s = loop_wrap_s ? '0 : rd_ptr_q;
    assign rd_elig_s    = (rd_ptr_arb_s < wr_level_q) && credit_ok_s;
    assign cmd_left_s   = app_en_q && !app_rdy;
    assign data_left_s  = wren_q && !app_wdf_rdy;

    // Arbitration, beat sequencing and next values of every registered output.
    always_comb begin
        state_d      = state_q;
        wr_level_d   = wr_level_q;
        rd_ptr_d     = rd_ptr_q;
        beat_d       = beat_q;
        last_rd_d    = last_rd_q;
        clear_pend_d = clear_pend_q | clear;
        app_en_d     = app_en_q;
        wren_d       = wren_q;
        pop_d        = 1'b0;
        app_cmd_d    = app_cmd_q;
        app_addr_d   = app_addr_q;
        case (state_q)
            ST_IDLE: begin
                app_en_d = 1'b0;
                wren_d   = 1'b0;
                if (init_calib_complete) begin
                    state_d = ST_ARB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (!init_calib_complete) begin
                    state_d = ST_IDLE;
                end else if (clear_pend_q) begin
                    wr_level_d   = '0;
                    rd_ptr_d     = '0;
                    clear_pend_d = clear;
                end else begin
                    rd_ptr_d = rd_ptr_arb_s;
                    if (wr_elig_s && (!rd_elig_s || last_rd_q)) begin
                        state_d    = ST_WR;
                        last_rd_d  = 1'b0;
                        beat_d     = '0;
                        app_en_d   = 1'b1;
                        wren_d     = 1'b1;
                        app_cmd_d  = CMD_WRITE;
                        app_addr_d = ADDR_W'(word_addr(wr_level_q, ADDR_STEP));
                    end else if (rd_elig_s) begin
                        state_d    = ST_RD;
                        last_rd_d  = 1'b1;
                        beat_d     = '0;
                        app_en_d   = 1'b1;
                        app_cmd_d  = CMD_READ;
                        app_addr_d = ADDR_W'(word_addr(rd_ptr_arb_s, ADDR_STEP));
                    end else begin
                        state_d = ST_ARB;
                    end
                end
            end
            ST_WR: begin
                if (pop_q) begin
                    // FIFO head advances during this cycle; the next beat starts after it.
                    if (init_calib_complete && (beat_q < BEAT_W'(BURST_LEN)) && wr_elig_s) begin
                        app_en_d   = 1'b1;
                        wren_d     = 1'b1;
                        app_addr_d = ADDR_W'(word_addr(wr_level_q, ADDR_STEP));
                    end else if (init_calib_complete) begin
                        state_d = ST_ARB;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    app_en_d = cmd_left_s;
                    wren_d   = data_left_s;
                    if (!cmd_left_s && !data_left_s) begin
                        pop_d      = 1'b1;
                        wr_level_d = wr_level_q + PTR_W'(1);
                        beat_d     = beat_q + BEAT_W'(1);
                    end else begin
                        pop_d = 1'b0;
                    end
                end
            end
            ST_RD: begin
                if (rd_accept_s) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    beat_d   = beat_q + BEAT_W'(1);
                    if (init_calib_complete && (beat_d < BEAT_W'(BURST_LEN))
                        && (rd_ptr_d < wr_level_q) && credit_ok_s) begin
                        app_en_d   = 1'b1;
                        app_addr_d = ADDR_W'(word_addr(rd_ptr_d, ADDR_STEP));
                    end else begin
                        app_en_d = 1'b0;
                        state_d  = init_calib_complete ? ST_ARB : ST_IDLE;
                    end
                end else if (!app_en_q) begin
                    state_d = ST_ARB;
                end else begin
                    app_en_d = 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                app_en_d = 1'b0;
                wren_d   = 1'b0;
            end
        endcase
        busy_d = (state_d == ST_WR) || (state_d == ST_RD);
    end

    // State, pointer and output registers.
    always_ff @(posedge clk) begin
        if (!sys_rst) begin
            state_q      <= ST_IDLE;
            wr_level_q   <= '0;
            rd_ptr_q     <= '0;
            beat_q       <= '0;
            last_rd_q    <= 1'b1;
            clear_pend_q <= 1'b0;
            app_en_q     <= 1'b0;
            wren_q       <= 1'b0;
            pop_q        <= 1'b0;
            busy_q       <= 1'b0;
            app_cmd_q    <= CMD_WRITE;
            app_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_level_q   <= wr_level_d;
            rd_ptr_q     <= rd_ptr_d;
            beat_q       <= beat_d;
            last_rd_q    <= last_rd_d;
            clear_pend_q <= clear_pend_d;
            app_en_q     <= app_en_d;
            wren_q       <= wren_d;
            pop_q        <= pop_d;
            busy_q       <= busy_d;
            app_cmd_q    <= app_cmd_d;
            app_addr_q   <= app_addr_d;
        end
    end

    // The FWFT head is held until popped, so it is stable for the whole data phase.
    assign app_wdf_data  = wr_fifo_dout & {DATA_W{wren_q}};
    assign app_wdf_wren  = wren_q;
    assign app_wdf_end   = wren_q;
    assign app_en        = app_en_q;
    assign app_cmd       = app_cmd_q;
    assign app_addr      = app_addr_q;
    assign wr_fifo_rd_en = pop_q;
    assign wr_level      = wr_level_q;
    assign rd_ptr        = rd_ptr_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_ddr3_app_scheduler.sv
// Directed bench for ddr3_app_scheduler with a small write-FIFO and read-return model.
module tb_ddr3_app_scheduler;

    localparam int ADDR_W = 29;
    localparam int DATA_W = 256;
    localparam int CNT_W  = 10;

    logic              clk = 1'b0;
    logic              sys_rst, init_calib_complete, clear, loop_en;
    logic [DATA_W-1:0] wr_fifo_dout;
    logic [CNT_W-1:0]  wr_fifo_count, rd_fifo_space;
    logic              wr_fifo_rd_en;
    logic [ADDR_W-1:0] app_addr;
    logic [2:0]        app_cmd;
    logic              app_en, app_rdy;
    logic [DATA_W-1:0] app_wdf_data;
    logic              app_wdf_wren, app_wdf_end, app_wdf_rdy, app_rd_data_valid;
    logic [20:0]       wr_level, rd_ptr;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int fifo_cnt = 0;
    int fifo_head = 0;
    int pops = 0;
    bit auto_valid = 1'b0;
    logic prev_busy = 1'b0;
    logic [ADDR_W-1:0] wr_addrs[$];
    logic [ADDR_W-1:0] rd_addrs[$];
    logic [2:0]        grants[$];
    int                burst_sz[$];

    always #5 clk = ~clk;

    ddr3_app_scheduler dut (
        .clk(clk), .sys_rst(sys_rst), .init_calib_complete(init_calib_complete),
        .clear(clear), .loop_en(loop_en), .wr_fifo_dout(wr_fifo_dout),
        .wr_fifo_count(wr_fifo_count), .wr_fifo_rd_en(wr_fifo_rd_en),
        .rd_fifo_space(rd_fifo_space), .app_addr(app_addr), .app_cmd(app_cmd),
        .app_en(app_en), .app_rdy(app_rdy), .app_wdf_data(app_wdf_data),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_rdy(app_wdf_rdy), .app_rd_data_valid(app_rd_data_valid),
        .wr_level(wr_level), .rd_ptr(rd_ptr), .busy(busy)
    );

    function automatic logic [DATA_W-1:0] fifo_word(input int h);
        return {8{32'hD0D0_0000 | 32'(h)}};
    endfunction

    task automatic drive_fifo();
        wr_fifo_count = CNT_W'(fifo_cnt);
        wr_fifo_dout  = fifo_word(fifo_head);
    endtask

    task automatic load_fifo(input int n);
        fifo_cnt = n;
        drive_fifo();
    endtask

    // One clock: sample pre-edge handshakes, advance models, drive post-edge inputs.
    task automatic step();
        logic pop_b, wacc_b, racc_b;
        logic [ADDR_W-1:0] addr_b;
        pop_b  = wr_fifo_rd_en;
        wacc_b = app_en && app_rdy && (app_cmd == 3'b000);
        racc_b = app_en && app_rdy && (app_cmd == 3'b001);
        addr_b = app_addr;
        @(posedge clk);
        #1;
        if (pop_b) begin
            pops++;
            if (fifo_cnt > 0) begin
                fifo_cnt--;
                fifo_head++;
            end
        end
        if (wacc_b) begin
            wr_addrs.push_back(addr_b);
            if (burst_sz.size() > 0) burst_sz[burst_sz.size()-1] += 1;
        end
        if (racc_b) rd_addrs.push_back(addr_b);
        if (busy && !prev_busy) begin
            grants.push_back(app_cmd);
            burst_sz.push_back(0);
        end
        prev_busy = busy;
        app_rd_data_valid = auto_valid ? racc_b : 1'b0;
        drive_fifo();
    endtask

    task automatic do_reset();
        sys_rst = 1'b0;
        step();
        sys_rst = 1'b1;
        wr_addrs.delete();
        rd_addrs.delete();
        grants.delete();
        burst_sz.delete();
        pops = 0;
        prev_busy = 1'b0;
    endtask

    task automatic test_reset();
        init_calib_complete = 1'b0;
        load_fifo(4);
        do_reset();
        checks++;
        if ({app_en, app_wdf_wren, app_wdf_end, wr_fifo_rd_en, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {app_en, app_wdf_wren, app_wdf_end, wr_fifo_rd_en, busy});
        end
        checks++;
        if (app_cmd !== 3'b000 || app_addr !== '0 || app_wdf_data !== '0) begin
            errors++;
            $display("FAIL reset_cmd_addr_data: cmd %0d addr %0d expected 0", app_cmd, app_addr);
        end
        checks++;
        if (wr_level !== 21'd0 || rd_ptr !== 21'd0) begin
            errors++;
            $display("FAIL reset_ptrs: wr_level %0d rd_ptr %0d expected 0", wr_level, rd_ptr);
        end
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (grants.size() != 0 || pops != 0) begin
            errors++;
            $display("FAIL idle_until_calib: grants %0d pops %0d expected 0", grants.size(), pops);
        end
        init_calib_complete = 1'b1;
    endtask

    task automatic test_write_burst();
        int n;
        int exp_b[3];
        int got;
        exp_b = '{8, 8, 4};
        rd_fifo_space = '0;
        load_fifo(20);
        do_reset();
        n = 0;
        while (!(wr_level == 21'd20 && !busy) && n < 300) begin step(); n++; end
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (wr_level !== 21'd20) begin
            errors++;
            $display("FAIL wr20_level: got %0d expected 20", wr_level);
        end
        checks++;
        if (pops != 20) begin
            errors++;
            $display("FAIL wr20_pops: got %0d expected 20", pops);
        end
        checks++;
        if (burst_sz.size() != 3) begin
            errors++;
            $display("FAIL wr20_nbursts: got %0d expected 3", burst_sz.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < burst_sz.size()) ? burst_sz[i] : -1;
            checks++;
            if (got != exp_b[i]) begin
                errors++;
                $display("FAIL wr20_burst%0d: got %0d expected %0d", i, got, exp_b[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            got = (i < wr_addrs.size()) ? int'(wr_addrs[i]) : -1;
            checks++;
            if (got != 8 * i) begin
                errors++;
                $display("FAIL wr20_addr%0d: got %0d expected %0d", i, got, 8 * i);
            end
        end
        checks++;
        if (rd_addrs.size() != 0) begin
            errors++;
            $display("FAIL wr20_no_reads: got %0d expected 0", rd_addrs.size());
        end
    endtask

    task automatic test_wdf_stall();
        int n;
        logic [DATA_W-1:0] exp_w;
        rd_fifo_space = '0;
        app_wdf_rdy = 1'b0;
        load_fifo(1);
        do_reset();
        exp_w = fifo_word(fifo_head);
        n = 0;
        while (!app_en && n < 50) begin step(); n++; end
        checks++;
        if (!(app_en === 1'b1 && app_wdf_wren === 1'b1 && app_wdf_end === 1'b1)) begin
            errors++;
            $display("FAIL stall_start: en %b wren %b end %b expected 1 1 1",
                     app_en, app_wdf_wren, app_wdf_end);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (app_en !== 1'b0 || app_wdf_wren !== 1'b1 || wr_fifo_rd_en !== 1'b0
                || app_wdf_data !== exp_w) begin
                errors++;
                $display("FAIL stall_hold%0d: en %b wren %b pop %b data %h", i,
                         app_en, app_wdf_wren, wr_fifo_rd_en, app_wdf_data[31:0]);
            end
        end
        checks++;
        if (wr_addrs.size() != 1) begin
            errors++;
            $display("FAIL stall_cmd_once: got %0d expected 1", wr_addrs.size());
        end
        app_wdf_rdy = 1'b1;
        step();
        checks++;
        if (wr_fifo_rd_en !== 1'b1 || app_wdf_wren !== 1'b0) begin
            errors++;
            $display("FAIL stall_pop: pop %b wren %b expected 1 0", wr_fifo_rd_en, app_wdf_wren);
        end
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (pops != 1 || wr_level !== 21'd1) begin
            errors++;
            $display("FAIL stall_single_pop: pops %0d wr_level %0d expected 1 1", pops, wr_level);
        end
    endtask

    task automatic fill_words(input int nw);
        int n;
        rd_fifo_space = '0;
        auto_valid = 1'b0;
        load_fifo(nw);
        do_reset();
        n = 0;
        while (!(wr_level == 21'(nw) && !busy) && n < 300) begin step(); n++; end
        checks++;
        if (wr_level !== 21'(nw)) begin
            errors++;
            $display("FAIL fill_%0d: got %0d expected %0d", nw, wr_level, nw);
        end
        rd_addrs.delete();
    endtask

    task automatic test_read_credit();
        fill_words(16);
        rd_fifo_space = CNT_W'(3);
        for (int i = 0; i < 40; i++) step();
        checks++;
        if (rd_addrs.size() != 3) begin
            errors++;
            $display("FAIL credit_3reads: got %0d expected 3", rd_addrs.size());
        end
        for (int k = 0; k < 2; k++) begin
            app_rd_data_valid = 1'b1;
            step();
            for (int i = 0; i < 15; i++) step();
            checks++;
            if (rd_addrs.size() != 4 + k) begin
                errors++;
                $display("FAIL credit_release%0d: reads %0d expected %0d", k, rd_addrs.size(), 4 + k);
            end else if (rd_addrs[3 + k] !== ADDR_W'(8 * (3 + k))) begin
                errors++;
                $display("FAIL credit_addr%0d: got %0d expected %0d", k, rd_addrs[3 + k], 8 * (3 + k));
            end
        end
    endtask

    task automatic test_alternate();
        int n;
        logic [2:0] exp_g[4];
        exp_g = '{3'b000, 3'b001, 3'b000, 3'b001};
        rd_fifo_space = CNT_W'(64);
        auto_valid = 1'b1;
        load_fifo(40);
        do_reset();
        n = 0;
        while (grants.size() < 4 && n < 400) begin step(); n++; end
        checks++;
        if (grants.size() < 4) begin
            errors++;
            $display("FAIL alt_timeout: grants %0d expected 4", grants.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (grants[i] !== exp_g[i]) begin
                    errors++;
                    $display("FAIL alt_grant%0d: got cmd %0d expected %0d", i, grants[i], exp_g[i]);
                end
            end
        end
        auto_valid = 1'b0;
        app_rd_data_valid = 1'b0;
    endtask

    task automatic test_loop();
        int got;
`ifdef DDR3_SCHED_LOOP_EN
        localparam int LOOP_N = 6;
`else
        localparam int LOOP_N = 4;
`endif
        fill_words(4);
        loop_en = 1'b1;
        rd_fifo_space = CNT_W'(64);
        auto_valid = 1'b1;
        for (int i = 0; i < 40; i++) step();
        for (int i = 0; i < LOOP_N; i++) begin
            got = (i < rd_addrs.size()) ? int'(rd_addrs[i]) : -1;
            checks++;
            if (got != 8 * (i % 4)) begin
                errors++;
                $display("FAIL loop_addr%0d: got %0d expected %0d", i, got, 8 * (i % 4));
            end
        end
`ifndef DDR3_SCHED_LOOP_EN
        checks++;
        if (rd_addrs.size() != 4 || rd_ptr !== 21'd4) begin
            errors++;
            $display("FAIL loop_stop: reads %0d rd_ptr %0d expected 4 4", rd_addrs.size(), rd_ptr);
        end
`endif
        loop_en = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 30; i++) step();
        checks++;
        if (wr_level !== 21'd0 || rd_ptr !== 21'd0) begin
            errors++;
            $display("FAIL clear_ptrs: wr_level %0d rd_ptr %0d expected 0 0", wr_level, rd_ptr);
        end
        auto_valid = 1'b0;
        app_rd_data_valid = 1'b0;
    endtask

    task automatic test_reset_mid_wr();
        int n;
        rd_fifo_space = '0;
        load_fifo(10);
        do_reset();
        n = 0;
        while (!(wr_level >= 21'd2 && busy && app_en) && n < 100) begin step(); n++; end
        checks++;
        if (!(busy && app_en)) begin
            errors++;
            $display("FAIL rstwr_timeout: busy %b en %b expected 1 1", busy, app_en);
        end
        sys_rst = 1'b0;
        step();
        sys_rst = 1'b1;
        checks++;
        if ({app_en, app_wdf_wren, app_wdf_end, wr_fifo_rd_en, busy} !== 5'b0
            || app_cmd !== 3'b000 || app_addr !== '0 || app_wdf_data !== '0) begin
            errors++;
            $display("FAIL rstwr_outputs: ctrl %b cmd %0d addr %0d expected all 0",
                     {app_en, app_wdf_wren, app_wdf_end, wr_fifo_rd_en, busy}, app_cmd, app_addr);
        end
        checks++;
        if (wr_level !== 21'd0 || rd_ptr !== 21'd0) begin
            errors++;
            $display("FAIL rstwr_ptrs: wr_level %0d rd_ptr %0d expected 0 0", wr_level, rd_ptr);
        end
    endtask

    initial begin
        sys_rst = 1'b0;
        init_calib_complete = 1'b0;
        clear = 1'b0;
        loop_en = 1'b0;
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        app_rd_data_valid = 1'b0;
        rd_fifo_space = '0;
        load_fifo(0);
        test_reset();
        test_write_burst();
        test_wdf_stall();
        test_read_credit();
        test_alternate();
        test_loop();
        test_reset_mid_wr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
